// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: per-device transmit FIFO feeding the bus generator/arbiter.
// The device side pushes packets; the arbiter consumes the head via pop.
// The head is presented first-word-fall-through on D_pop, qualified by pndng.
// Optional feature macro: DEV_FIFO_DROP_CNT_EN adds a saturating drop_cnt port.
module bus_dev_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       full,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  output logic                       pndng,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
`ifdef DEV_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [pckg_sz-1:0] mem [depth];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic pop_acc;
  logic push_acc;
  logic push_drop;

  // Status is decoded purely from the occupancy register.
  assign pndng = (count_q != '0);
  assign full  = (count_q == CW'(depth));
  assign count = count_q;

  // A pop frees a slot in the same cycle, so a push while full still fits.
  assign pop_acc   = pop & pndng;
  assign push_acc  = push & (~full | pop_acc);
  assign push_drop = push & ~push_acc;

  // Head mux; zero when empty so stale memory never leaks onto the bus.
  assign D_pop = pndng ? mem[rd_ptr_q] : '0;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);

    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CW'(1);

    if (push_drop)       overflow_d  = 1'b1;
    if (pop && !pndng)   underflow_d = 1'b1;
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: memory has no reset; count gates visibility, so stale contents are never seen.
    if (push_acc && !reset) mem[wr_ptr_q] <= D_push;
  end

`ifdef DEV_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped pushes.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Self-checking bench for bus_dev_fifo using a queue scoreboard.
module tb_bus_dev_fifo;

  localparam int PSZ   = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           push;
  logic [PSZ-1:0] D_push;
  logic           full;
  logic           pop;
  logic [PSZ-1:0] D_pop;
  logic           pndng;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           underflow;
`ifdef DEV_FIFO_DROP_CNT_EN
  logic [7:0]     drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [PSZ-1:0] exp_q[$];
  logic           m_ovf;
  logic           m_udf;
  int             m_drop;

  always #5 clk = ~clk;

  bus_dev_fifo #(.pckg_sz(PSZ), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .D_push    (D_push),
    .full      (full),
    .pop       (pop),
    .D_pop     (D_pop),
    .pndng     (pndng),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef DEV_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare every visible output against the scoreboard model.
  task automatic check_state(input string tag);
    logic [PSZ-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_pndng"}, 32'(pndng), 32'(exp_q.size() != 0));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, "_head"}, 32'(D_pop), 32'(head));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_udf"}, 32'(underflow), 32'(m_udf));
`ifdef DEV_FIFO_DROP_CNT_EN
    check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // One clock of stimulus; pop data is checked in the cycle the pop is issued.
  task automatic step(input logic p, input logic [PSZ-1:0] d, input logic o, input string tag);
    bit pop_ok, push_ok, m_full;
    @(negedge clk);
    push = p; D_push = d; pop = o;
    m_full  = (exp_q.size() == DEPTH);
    pop_ok  = o && (exp_q.size() != 0);
    push_ok = p && (!m_full || pop_ok);
    if (o && !pop_ok) m_udf = 1'b1;
    if (p && !push_ok) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    #1;
    if (pop_ok) check({tag, "_popdata"}, 32'(D_pop), 32'(exp_q.pop_front()));
    if (push_ok) exp_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_drop = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; D_push = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_state("reset_idle");

    // Fill to full, then one dropped push.
    for (int i = 0; i < DEPTH; i++) step(1'b1, PSZ'(16'h0101 + i), 1'b0, "fill");
    check("fill_full", 32'(full), 32'd1);
    check("fill_head", 32'(D_pop), 32'h0101);
    step(1'b1, 16'hFF09, 1'b0, "drop");
    check("drop_ovf", 32'(overflow), 32'd1);

    // Push and pop together while full.
    step(1'b1, 16'h0209, 1'b1, "full_pushpop");
    check("full_pushpop_cnt", 32'(count), 32'd8);

    // Drain everything.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");
    check("drain_pndng", 32'(pndng), 32'd0);

    // Empty boundaries.
    step(1'b0, '0, 1'b1, "empty_pop");
    step(1'b1, 16'hFFAA, 1'b1, "empty_pushpop");
    check("empty_pushpop_head", 32'(D_pop), 32'hFFAA);
    step(1'b0, '0, 1'b1, "empty_drain");

    // Wrap-around with interleaved push/pop.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, PSZ'(16'h1000 + i), 1'b0, "wrap_push");
      check("wrap_cnt_le1", 32'(count <= 1), 32'd1);
      step(1'b0, '0, 1'b1, "wrap_pop");
    end

    // Reset mid-stream with 5 entries held.
    for (int i = 0; i < 5; i++) step(1'b1, PSZ'(16'h0500 + i), 1'b0, "pre_rst");
    step(1'b0, '0, 1'b1, "pre_rst_udf");
    step(1'b0, '0, 1'b1, "pre_rst_pop");
    for (int i = 0; i < 2; i++) step(1'b1, PSZ'(16'h0600 + i), 1'b0, "pre_rst2");
    check("pre_rst_cnt", 32'(count), 32'd5);
    @(negedge clk);
    reset = 1'b1; push = 1'b1; D_push = 16'hDEAD; pop = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk);
    #1;
    check_state("rst_cycle");
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    step(1'b1, 16'h0303, 1'b0, "post_rst");
    check("post_rst_head", 32'(D_pop), 32'h0303);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Per-device transmit FIFO that sits directly upstream of the bus generator/arbiter (`bs_gnrtr_n_rbtr`). The device-side agent/driver writes packets in. The FIFO presents its head packet to the bus as `D_pop` with `pndng` asserted. The bus consumes the head by pulsing `pop`. One instance is placed per device per bus, and drives that device's `pndng`/`D_pop` slice.

## Interface
Parameters:
- `pckg_sz`, 16, packet width in bits; the top 8 bits are the destination ID, where `{8{1'b1}}` means broadcast.
- `depth`, 8, number of entries; must be a power of two and at least 2.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `push`  input  1  write request from the device side.
- `D_push`  input  pckg_sz  write data, sampled with `push`.
- `full`  output  1  FIFO holds `depth` entries.
- `pop`  input  1  read/consume request from the bus arbiter.
- `D_pop`  output  pckg_sz  head packet, first-word-fall-through.
- `pndng`  output  1  FIFO not empty (head valid).
- `count`  output  $clog2(depth+1)  current occupancy.
- `overflow`  output  1  sticky flag: a push was dropped.
- `underflow`  output  1  sticky flag: a pop was issued while empty.
- `drop_cnt`  output  8  saturating dropped-push counter. Present only when `DEV_FIFO_DROP_CNT_EN` is defined.

## Operation
- Storage: a `depth`-entry array with read and write pointers of $clog2(depth) bits. Pointers wrap modulo `depth`. Occupancy is tracked by the `count` register, not by pointer comparison.
- Status is decoded from `count`:
  - `pndng` = (`count` != 0)
  - `full` = (`count` == `depth`)
- `D_pop` = `mem[rd_ptr]` when `pndng` is 1; it is forced to 0 when `pndng` is 0.
- A push is accepted when `push` is 1 and either `full` is 0 or an accepted pop occurs in the same cycle.
  - On acceptance: `mem[wr_ptr]` <= `D_push` and `wr_ptr` increments.
- A pop is accepted when `pop` is 1 and `pndng` is 1.
  - On acceptance: `rd_ptr` increments.
- Update of `count` per cycle:
  - +1 when only a push is accepted.
  - −1 when only a pop is accepted.
  - Unchanged when both or neither are accepted.
- Boundary cases:
  - Push while full with no pop: the write is dropped, memory and pointers are unchanged, and `overflow` <= 1.
  - Push and pop together while full: both are accepted, and `count` stays at `depth`.
  - Push and pop together while empty: the pop is ignored and `underflow` <= 1; the push is accepted and `count` becomes 1.
  - Pop while empty with no push: ignored, and `underflow` <= 1.
- `overflow` and `underflow` clear only on `reset`.
- Packet contents, including the destination/broadcast field, pass through unmodified. Routing is the arbiter's job.

## Timing
- Reset (asynchronous, immediate on `reset` rising) forces:
  - `rd_ptr`, `wr_ptr` and `count` to 0.
  - `pndng` = 0, `full` = 0, `D_pop` = 0, `overflow` = 0, `underflow` = 0, `drop_cnt` = 0.
- Memory contents are not reset.
- Push → visible latency is 1 cycle: a push accepted at edge N raises `pndng`, and drives `D_pop` with that data, immediately after edge N.
- Pop → next head: after a pop accepted at edge N, `D_pop` shows the next entry (or 0 if the FIFO is now empty) immediately after edge N.
- The arbiter may sample `D_pop` in the same cycle it asserts `pop`. The data is stable for the whole cycle.
- Reset mid-operation: all contents are discarded, and any `push`/`pop` in the reset cycle is ignored. Normal operation resumes on the first edge after `reset` deasserts.
- There is no internal state machine beyond the pointers and count. All outputs except `D_pop` are registered or decoded from registers. `D_pop` is a mux from registered state only.

## Configuration
- `DEV_FIFO_DROP_CNT_EN`:
  - Defined: the `drop_cnt` port exists. It increments by 1 on each dropped push, saturates at 255, and clears only on `reset`.
  - Undefined: the port and its logic are absent, and `overflow` is the only drop indication.

## Test plan
- Reset then idle → `pndng`=0, `full`=0, `count`=0, `D_pop`=0, both flags 0.
- Push 0x0101…0x0108 (`depth`=8) on consecutive cycles → `count`=8, `full`=1, `D_pop`=0x0101. A 9th push of 0xFF09 is dropped, giving `overflow`=1 and (with the macro) `drop_cnt`=1.
- From full, push 0x0209 with a simultaneous pop → `count` stays 8. Popping all 8 entries returns 0x0102…0x0108, then 0x0209, and `pndng` falls after the last pop.
- Pop while empty, and pop plus push of 0xFFAA while empty → `underflow`=1, `count`=1, `D_pop`=0xFFAA.
- Wrap-around: 20 interleaved push/pop pairs with an incrementing pattern → output order exactly matches input order, and `count` never exceeds 1.
- Assert `reset` mid-stream while `count`=5 → all outputs return to their reset values within the same cycle. The next push of 0x0303 appears on `D_pop` one edge later.
